mem_access_stage: RTL

Memory-access stage of the MIPS pipeline: sits directly downstream of the EX/MEM pipeline register and upstream of write-back. Consumes the M-stage control/data bundle, runs a req/ack transaction on the data-memory port with byte-lane strobes, aligns and extends load data, stalls the pipeline while memory is busy, and registers the result into the MEM/WB outputs.

---
 rtl/mem_access_stage.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS memory-access (M) stage.
// Issues one req/ack transaction per aligned load/store on the data-memory
// port (lane-replicated store data, byte enables), aligns and extends load
// data, stalls the pipeline while the bus is busy and registers the MEM/WB
// bundle. Misaligned accesses are dropped without a bus cycle.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   Mem_Read_M .. data_size_M  M-stage control/data bundle from EX/MEM
//   dmem_req/we/addr/be/wdata  registered data-memory request
//   dmem_rdata, dmem_ack       data-memory response
//   Stall_M                    combinational freeze for upstream stages
//   *_W                        registered MEM/WB outputs
//
// Optional feature macro: MEM_TIMEOUT_EN -- aborts a BUSY transaction after
// TIMEOUT_CYCLES cycles without ack and raises Bus_Err_W for one cycle.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Mem_Read_M,
    input  logic        Mem_Write_M,
    input  logic        Mem_To_Reg_M,
    input  logic        Reg_Write_M,
    input  logic        Load_Unsigned_M,
    input  logic [31:0] ALU_Result_M,
    input  logic [31:0] Write_Data_M,
    input  logic [4:0]  Write_Reg_M,
    input  logic [1:0]  data_size_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        Stall_M,
    output logic [31:0] Read_Data_W,
    output logic [31:0] ALU_Result_W,
    output logic [4:0]  Write_Reg_W,
    output logic        Reg_Write_W,
    output logic        Mem_To_Reg_W,
    output logic        Misalign_W,
    output logic        Bus_Err_W
);

    localparam int unsigned TMO_W = 8;

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

    // The timeout counter is 8 bits wide; reject unreachable limits.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic        ld_uns_q, ld_uns_d;
    logic [31:0] rd_w_q, rd_w_d;
    logic [31:0] alu_w_q, alu_w_d;
    logic [4:0]  wreg_w_q, wreg_w_d;
    logic        rw_w_q, rw_w_d;
    logic        mtr_w_q, mtr_w_d;
    logic        mis_w_q, mis_w_d;
    logic        berr_w_q, berr_w_d;

    logic        access;
    logic        misaligned;
    logic        timeout_hit;
    logic        stall;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_c;

    assign access     = Mem_Read_M | Mem_Write_M;
    assign misaligned = ((data_size_M == 2'b01) & ALU_Result_M[0])
                      | (data_size_M[1] & (ALU_Result_M[1:0] != 2'b00));

    // Byte-lane enables and replicated store data for the current M op.
    always_comb begin : store_lanes
        be_c    = 4'b1111;
        wdata_c = Write_Data_M;
        case (data_size_M)
            2'b00: begin
                be_c    = 4'(4'b0001 << ALU_Result_M[1:0]);
                wdata_c = {4{Write_Data_M[7:0]}};
            end
            2'b01: begin
                be_c    = ALU_Result_M[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{Write_Data_M[15:0]}};
            end
            default: ;
        endcase
    end

    // Load alignment uses the size/offset latched at issue.
    always_comb begin : load_align
        ld_byte = 8'(dmem_rdata >> {ld_off_q, 3'b000});
        ld_half = ld_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ld_size_q)
            2'b00:   load_c = ld_uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_c = ld_uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_c = dmem_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counts BUSY cycles without ack; cleared while idle.
    always_comb begin : tmo_next
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == S_IDLE) begin
            tmo_cnt_d = '0;
        end else if (!dmem_ack) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : tmo_reg
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit = (state_q == S_BUSY) && !dmem_ack
                      && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state, bus request and MEM/WB bundle.
    always_comb begin : fsm_next
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        ld_size_d = ld_size_q;
        ld_off_d  = ld_off_q;
        ld_uns_d  = ld_uns_q;
        rd_w_d    = rd_w_q;
        alu_w_d   = ALU_Result_M;
        wreg_w_d  = Write_Reg_M;
        rw_w_d    = Reg_Write_M;
        mtr_w_d   = Mem_To_Reg_M;
        mis_w_d   = 1'b0;
        berr_w_d  = 1'b0;
        stall     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        rw_w_d  = 1'b0;
                        mis_w_d = 1'b1;
                    end else begin
                        req_d     = 1'b1;
                        we_d      = Mem_Write_M;
                        addr_d    = {ALU_Result_M[31:2], 2'b00};
                        be_d      = be_c;
                        wdata_d   = wdata_c;
                        ld_size_d = data_size_M;
                        ld_off_d  = ALU_Result_M[1:0];
                        ld_uns_d  = Load_Unsigned_M;
                        state_d   = S_BUSY;
                        stall     = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                    if (!we_q) begin
                        rd_w_d = load_c;
                    end
                end else if (timeout_hit) begin
                    // Abort: release the pipeline but drop the instruction.
                    req_d    = 1'b0;
                    state_d  = S_IDLE;
                    rw_w_d   = 1'b0;
                    mtr_w_d  = 1'b0;
                    alu_w_d  = alu_w_q;
                    wreg_w_d = wreg_w_q;
                    berr_w_d = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
        endcase

        // Bubble into WB while stalled; data fields hold.
        if (stall) begin
            rw_w_d   = 1'b0;
            mtr_w_d  = 1'b0;
            alu_w_d  = alu_w_q;
            wreg_w_d = wreg_w_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            ld_size_q <= '0;
            ld_off_q  <= '0;
            ld_uns_q  <= 1'b0;
            rd_w_q    <= '0;
            alu_w_q   <= '0;
            wreg_w_q  <= '0;
            rw_w_q    <= 1'b0;
            mtr_w_q   <= 1'b0;
            mis_w_q   <= 1'b0;
            berr_w_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            ld_size_q <= ld_size_d;
            ld_off_q  <= ld_off_d;
            ld_uns_q  <= ld_uns_d;
            rd_w_q    <= rd_w_d;
            alu_w_q   <= alu_w_d;
            wreg_w_q  <= wreg_w_d;
            rw_w_q    <= rw_w_d;
            mtr_w_q   <= mtr_w_d;
            mis_w_q   <= mis_w_d;
            berr_w_q  <= berr_w_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;
    assign Stall_M      = stall;
    assign Read_Data_W  = rd_w_q;
    assign ALU_Result_W = alu_w_q;
    assign Write_Reg_W  = wreg_w_q;
    assign Reg_Write_W  = rw_w_q;
    assign Mem_To_Reg_W = mtr_w_q;
    assign Misalign_W   = mis_w_q;
    assign Bus_Err_W    = berr_w_q;

endmodule
